// File: rtl/pe_pkg.sv
// pe_pkg: shared state encoding, sizing helper and default widths for the PE core
package pe_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_FILT, LOAD_WIN, MAC, EMIT, DONE} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_PSUM_W = 20;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/pe_mac_unit.sv
// pe_mac_unit: signed multiplier feeding a wrapping accumulator with sync clear and enable
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PSUM_W = DEF_PSUM_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [PSUM_W-1:0] acc
);
  logic signed [2*DATA_W-1:0] prod;
  logic        [PSUM_W-1:0]   prod_ext;
  assign prod     = a * b;
  assign prod_ext = {{(PSUM_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= clr ? '0 : en ? acc + prod_ext : acc;
  end
endmodule

// File: rtl/conv1d_pe_core.sv
// conv1d_pe_core: serial-MAC 1-D convolution PE; loads filter, slides window, emits one psum per window
module conv1d_pe_core
  import pe_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FILT_LEN  = 4,
  parameter int IFMAP_LEN = 16,
  parameter int STRIDE    = 1,
  parameter int PSUM_W    = DEF_PSUM_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     filt_valid,
  output logic                     filt_ready,
  input  logic        [DATA_W-1:0] filt_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [DATA_W-1:0] in_data,
  output logic                     psum_valid,
  input  logic                     psum_ready,
  output logic signed [PSUM_W-1:0] psum_data,
  output logic                     busy,
  output logic                     done
);
  localparam int NUM_OUT = (IFMAP_LEN - FILT_LEN) / STRIDE + 1;
  localparam int CW = clog2(FILT_LEN);
  localparam int OW = clog2(NUM_OUT + 1);
  state_t                   state;
  logic        [CW-1:0]     filt_cnt, win_cnt, mac_cnt, win_last;
  logic        [OW-1:0]     out_cnt;
  logic signed [DATA_W-1:0] filt [FILT_LEN];
  logic signed [DATA_W-1:0] win  [FILT_LEN];
  logic                     win_done;
  assign filt_ready = state == LOAD_FILT;
  assign in_ready   = state == LOAD_WIN;
  assign psum_valid = state == EMIT;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  // first window needs a full fill, later windows only advance by the stride
  assign win_last   = (out_cnt == '0) ? CW'(FILT_LEN - 1) : CW'(STRIDE - 1);
  assign win_done   = in_valid && in_ready && win_cnt == win_last;
  pe_mac_unit #(.DATA_W(DATA_W), .PSUM_W(PSUM_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (win_done),
    .en  (state == MAC),
    .a   (win[mac_cnt]),
    .b   (filt[mac_cnt]),
    .acc (psum_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      filt_cnt <= '0;
      win_cnt  <= '0;
      mac_cnt  <= '0;
      out_cnt  <= '0;
      for (int i = 0; i < FILT_LEN; i++) begin
        filt[i] <= '0;
        win[i]  <= '0;
      end
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state    <= LOAD_FILT;
          filt_cnt <= '0;
          win_cnt  <= '0;
          out_cnt  <= '0;
        end
        LOAD_FILT: if (filt_valid) begin
          filt[filt_cnt] <= filt_data;
          filt_cnt       <= (filt_cnt == CW'(FILT_LEN - 1)) ? '0 : filt_cnt + CW'(1);
          state          <= (filt_cnt == CW'(FILT_LEN - 1)) ? LOAD_WIN : LOAD_FILT;
        end
        LOAD_WIN: if (in_valid) begin
          for (int i = 0; i < FILT_LEN - 1; i++) win[i] <= win[i+1];
          win[FILT_LEN-1] <= in_data;
          win_cnt         <= win_done ? '0 : win_cnt + CW'(1);
          mac_cnt         <= '0;
          state           <= win_done ? MAC : LOAD_WIN;
        end
        MAC: begin
          mac_cnt <= mac_cnt + CW'(1);
          state   <= (mac_cnt == CW'(FILT_LEN - 1)) ? EMIT : MAC;
        end
        EMIT: if (psum_ready) begin
          out_cnt <= out_cnt + OW'(1);
          state   <= (out_cnt == OW'(NUM_OUT - 1)) ? DONE : LOAD_WIN;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv1d_pe_core.md
Name: conv1d_pe_core

Overview:
- Single processing element that consumes the IFmap and filter streams drained from the PE input buffers.
- Computes a 1-D convolution of FILT_LEN taps over IFMAP_LEN inputs at stride STRIDE.
- Emits one partial sum per output window to the psum output buffer over a valid/ready handshake.
- Serial MAC: one multiply-accumulate per cycle.

Parameters:
- DATA_W, 8, width of IFmap and filter words, two's-complement signed.
- FILT_LEN, 4, filter taps = sliding-window length (≥2).
- IFMAP_LEN, 16, IFmap words per run (≥FILT_LEN).
- STRIDE, 1, window advance in words. Requires 1≤STRIDE≤FILT_LEN and (IFMAP_LEN−FILT_LEN)%STRIDE==0.
- PSUM_W, 20, accumulator/output width, signed. Requires PSUM_W ≥ 2*DATA_W+clog2(FILT_LEN).

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle run request; honoured only in IDLE.
- filt_valid, input, 1, filter word available.
- filt_ready, output, 1, core accepts filter word.
- filt_data, input, DATA_W, filter word.
- in_valid, input, 1, IFmap word available.
- in_ready, output, 1, core accepts IFmap word.
- in_data, input, DATA_W, IFmap word.
- psum_valid, output, 1, psum_data valid.
- psum_ready, input, 1, downstream accepts psum.
- psum_data, output, PSUM_W, signed partial sum.
- busy, output, 1, high in any state except IDLE.
- done, output, 1, one-cycle pulse after the last psum is accepted.

Behaviour:
- Reset (rst=1, async): state=IDLE. All counters, filter regs, window regs and accumulator clear to 0. All outputs 0. Reset mid-run aborts with no further handshakes; the caller re-issues start.
- NUM_OUT = (IFMAP_LEN−FILT_LEN)/STRIDE + 1. Default 13.
- Handshake: a transfer occurs on a rising edge where valid & ready. filt_ready = (state==LOAD_FILT). in_ready = (state==LOAD_WIN). psum_valid = (state==EMIT). All three are decoded from registered state; no combinational path from valid to ready.
- IDLE: start=1 → LOAD_FILT next cycle. Clear filt_cnt, win_cnt, out_cnt. start in any other state is ignored.
- LOAD_FILT: each transfer writes filt[filt_cnt] and increments filt_cnt. The transfer with filt_cnt==FILT_LEN−1 → LOAD_WIN with win_need=FILT_LEN.
- LOAD_WIN: each transfer shifts the window: win[j]<=win[j+1], win[FILT_LEN−1]<=in_data (win[0] oldest). The transfer completing win_need words → MAC with mac_cnt=0 and acc=0.
- MAC: each cycle acc += sext(win[mac_cnt]) * sext(filt[mac_cnt]), then mac_cnt++. After FILT_LEN cycles → EMIT with psum_data=acc, registered.
- EMIT: psum_valid and psum_data hold stable until psum_ready.
  - On the handshake, out_cnt++.
  - If out_cnt was NUM_OUT−1 → DONE; else → LOAD_WIN with win_need=STRIDE.
- DONE: done=1 for exactly one cycle → IDLE. busy=0 once back in IDLE.
- Arithmetic: signed products are sign-extended to PSUM_W; sums wrap mod 2^PSUM_W (cannot occur under the parameter rule).
- Filter regs persist until the next start. Filter words are always reloaded per run.
- Latency with always-valid inputs and always-ready output:
  - start → filt_ready: 1 cycle.
  - Last window word accepted → psum_valid: FILT_LEN+1 cycles.
  - Per-output throughput: STRIDE+FILT_LEN+1 cycles.
- Stalls: valid low during a LOAD phase holds state and counters. psum_ready low holds EMIT indefinitely and loses no data.
- The core consumes exactly IFMAP_LEN IFmap words and FILT_LEN filter words per run.

Decomposition:
- Shared package pe_pkg:
  - state enum {IDLE, LOAD_FILT, LOAD_WIN, MAC, EMIT, DONE};
  - clog2 function;
  - default DATA_W/PSUM_W constants.
- One sub-module, pe_mac_unit: signed DATA_W×DATA_W multiplier plus PSUM_W accumulator with synchronous clear and enable, async rst.
- FSM, counters, filter and window registers stay in conv1d_pe_core.

Test Plan:
- Basic run, default parameters: filter [1,2,3,4], IFmap 1..16, inputs always valid, psum_ready=1.
  - Expect 13 psums 30,40,…,150 (10i+30).
  - Expect done pulse once, busy low afterwards.
- STRIDE=2: same stimulus.
  - Expect 7 psums 30,50,70,90,110,130,150.
  - Expect exactly 16 in_data transfers.
- Signed: filter [−1,0,0,1], IFmap 1..16.
  - Expect all 13 psums = 3.
  - Filter [−128,−128,−128,−128], IFmap all −128 → psum 65536.
- Backpressure and stalls: random in_valid/filt_valid gaps, psum_ready low for 5 cycles on output 3.
  - Expect psum_data stable while stalled.
  - Expect results identical to scenario 1.
- Reset mid-run: assert rst during MAC of output 5, then start a fresh run.
  - Expect all outputs 0 during reset.
  - Expect full correct 13-psum sequence after restart.
- start while busy: pulse start during LOAD_WIN and EMIT.
  - Expect no state change and no extra filter load.
